// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI responder.
// Holds the state enum, frame constants and the TX frame packer.
package jstk_pkg;

  localparam int         JSTK_BYTES      = 5;
  localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    LOAD,
    SHIFT,
    END
  } state_t;

  function automatic logic [39:0] pack_tx(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic [2:0] btn
  );
    return {x[7:0], 6'b0, x[9:8],
            y[7:0], 6'b0, y[9:8],
            5'b0, btn};
  endfunction

endpackage

// File: rtl/jstk_spi_responder_sync.sv
// Synchroniser and edge detector for the asynchronous SPI pins.
// Ports: clk, reset in; ss/sclk/mosi raw in; synced levels and edge pulses out.
module spi_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ss,
  input  logic sclk,
  input  logic mosi,
  output logic ss_lvl,
  output logic sck_lvl,
  output logic mosi_lvl,
  output logic ss_fall,
  output logic ss_rise,
  output logic sck_rise,
  output logic sck_fall
);

  logic [SYNC_STAGES-1:0] ss_c;
  logic [SYNC_STAGES-1:0] sck_c;
  logic [SYNC_STAGES-1:0] mosi_c;
  logic                   ss_d;
  logic                   sck_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_c   <= '0;
      sck_c  <= '0;
      mosi_c <= '0;
      ss_d   <= 1'b0;
      sck_d  <= 1'b0;
    end else begin
      ss_c   <= {ss_c[SYNC_STAGES-2:0], ss};
      sck_c  <= {sck_c[SYNC_STAGES-2:0], sclk};
      mosi_c <= {mosi_c[SYNC_STAGES-2:0], mosi};
      ss_d   <= ss_c[SYNC_STAGES-1];
      sck_d  <= sck_c[SYNC_STAGES-1];
    end
  end

  assign ss_lvl   = ss_c[SYNC_STAGES-1];
  assign sck_lvl  = sck_c[SYNC_STAGES-1];
  assign mosi_lvl = mosi_c[SYNC_STAGES-1];
  assign ss_fall  = ~ss_lvl & ss_d;
  assign ss_rise  = ss_lvl & ~ss_d;
  assign sck_rise = sck_lvl & ~sck_d;
  assign sck_fall = ~sck_lvl & sck_d;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK: returns X/Y/BTN, latches LEDs.
// Ports: CLK/RESET, SS/SCLK/MOSI/MISO, X_POS/Y_POS/BTN, LED, pulses.
// Optional JSTK_FRAME_CNT_EN adds FRAME_CNT[15:0] counting good frames.
module jstk_spi_responder
  import jstk_pkg::*;
#(
  parameter int BYTE_CNT    = JSTK_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SS,
  input  logic       SCLK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic [9:0] X_POS,
  input  logic [9:0] Y_POS,
  input  logic [2:0] BTN,
  output logic [1:0] LED,
  output logic       CMD_VALID,
  output logic       FRAME_DONE,
`ifdef JSTK_FRAME_CNT_EN
  output logic       FRAME_ERR,
  output logic [15:0] FRAME_CNT
`else
  output logic       FRAME_ERR
`endif
);

  logic ss_lvl, sck_lvl, mosi_lvl;
  logic ss_fall, ss_rise;
  logic sck_rise, sck_fall;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (CLK),
    .reset   (RESET),
    .ss      (SS),
    .sclk    (SCLK),
    .mosi    (MOSI),
    .ss_lvl  (ss_lvl),
    .sck_lvl (sck_lvl),
    .mosi_lvl(mosi_lvl),
    .ss_fall (ss_fall),
    .ss_rise (ss_rise),
    .sck_rise(sck_rise),
    .sck_fall(sck_fall)
  );

  state_t      state, state_n;
  logic [39:0] tx_sr;
  logic [7:0]  rx_sr;
  logic [7:0]  rx_nxt;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic        ss_hi;

  assign rx_nxt = {rx_sr[6:0], mosi_lvl};
  // A level check also catches an SS rise that landed during LOAD.
  assign ss_hi  = ss_rise | ss_lvl;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ARM;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    FRAME_DONE = 1'b0;
    FRAME_ERR  = 1'b0;
    unique case (state)
      ARM:   if (ss_lvl) state_n = IDLE;
      IDLE:  if (ss_fall) state_n = LOAD;
      LOAD:  state_n = SHIFT;
      SHIFT: if (ss_hi) state_n = END;
      END: begin
        state_n = IDLE;
        if (byte_cnt == 3'(BYTE_CNT) &&
            bit_cnt == 3'd0)
          FRAME_DONE = 1'b1;
        else
          FRAME_ERR = 1'b1;
      end
      default: state_n = ARM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      MISO      <= 1'b0;
      LED       <= 2'b00;
      CMD_VALID <= 1'b0;
    end else begin
      CMD_VALID <= 1'b0;
      unique case (state)
        IDLE: MISO <= 1'b0;
        LOAD: begin
          tx_sr    <= pack_tx(X_POS, Y_POS, BTN);
          MISO     <= X_POS[7];
          rx_sr    <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
        end
        SHIFT: begin
          if (!ss_hi) begin
            if (sck_rise) begin
              rx_sr   <= rx_nxt;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (byte_cnt != 3'd7)
                  byte_cnt <= byte_cnt + 3'd1;
                if (byte_cnt == 3'd0 &&
                    rx_nxt[7:2] == JSTK_CMD_PREFIX) begin
                  LED       <= rx_nxt[1:0];
                  CMD_VALID <= 1'b1;
                end
              end
            end else if (sck_fall) begin
              tx_sr <= {tx_sr[38:0], 1'b0};
              MISO  <= tx_sr[38];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef JSTK_FRAME_CNT_EN
  always_ff @(posedge CLK) begin
    if (RESET)           FRAME_CNT <= '0;
    else if (FRAME_DONE) FRAME_CNT <= FRAME_CNT + 16'd1;
  end
`endif

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench for jstk_spi_responder (directed + random frames).
// Uses a byte-level reference model of the joystick protocol.
module tb_jstk_spi_responder;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SS = 1'b0;
  logic       SCLK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] X_POS = '0;
  logic [9:0] Y_POS = '0;
  logic [2:0] BTN = '0;
  logic [1:0] LED;
  logic       CMD_VALID;
  logic       FRAME_DONE;
  logic       FRAME_ERR;
`ifdef JSTK_FRAME_CNT_EN
  logic [15:0] FRAME_CNT;
`endif

  jstk_spi_responder dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SS        (SS),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .X_POS     (X_POS),
    .Y_POS     (Y_POS),
    .BTN       (BTN),
    .LED       (LED),
    .CMD_VALID (CMD_VALID),
    .FRAME_DONE(FRAME_DONE),
`ifdef JSTK_FRAME_CNT_EN
    .FRAME_ERR (FRAME_ERR),
    .FRAME_CNT (FRAME_CNT)
`else
    .FRAME_ERR (FRAME_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cmd_cnt = 0;
  int m_done = 0;
  int m_err = 0;
  int m_cmd = 0;
  logic [1:0] m_led = 2'b00;
  logic [7:0] mo[8];
  logic [7:0] mi[8];

  always @(negedge CLK) begin
    if (FRAME_DONE === 1'b1) done_cnt++;
    if (FRAME_ERR === 1'b1) err_cnt++;
    if (CMD_VALID === 1'b1) cmd_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(
    input int x, input int y, input int b, input int k);
    case (k)
      0: return 8'(x % 256);
      1: return 8'(x / 256);
      2: return 8'(y % 256);
      3: return 8'(y / 256);
      4: return 8'(b);
      default: return 8'd0;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sck_pulse();
    tick(8);
    SCLK = 1'b1;
    tick(8);
    SCLK = 1'b0;
  endtask

  task automatic frame(input int nbits,
                       input int chg_bit,
                       input logic [9:0] chg_x);
    SS = 1'b0;
    tick(12);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[i/8][7 - (i % 8)];
      tick(8);
      SCLK = 1'b1;
      mi[i/8][7 - (i % 8)] = MISO;
      if (i == chg_bit) X_POS = chg_x;
      tick(8);
      SCLK = 1'b0;
    end
    tick(8);
    SS = 1'b1;
    tick(12);
  endtask

  task automatic run_frame(input string tag,
                           input int nbits,
                           input int chg_bit,
                           input logic [9:0] chg_x);
    int x, y, b;
    x = int'(X_POS);
    y = int'(Y_POS);
    b = int'(BTN);
    frame(nbits, chg_bit, chg_x);
    if (nbits >= 8 && (mo[0] / 4) == 32) begin
      m_led = 2'(mo[0] % 4);
      m_cmd++;
    end
    if (nbits == 40) m_done++;
    else             m_err++;
    for (int k = 0; k < nbits / 8 && k < 8; k++)
      check($sformatf("%s miso byte %0d", tag, k),
            32'(mi[k]), 32'(exp_byte(x, y, b, k)));
    check({tag, " led"}, 32'(LED), 32'(m_led));
    check({tag, " done"}, done_cnt, m_done);
    check({tag, " err"}, err_cnt, m_err);
    check({tag, " cmd"}, cmd_cnt, m_cmd);
`ifdef JSTK_FRAME_CNT_EN
    check({tag, " fcnt"}, 32'(FRAME_CNT),
          32'(m_done % 65536));
`endif
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mo[k] = 8'h00;
      mi[k] = 8'h00;
    end

    // Reset with SS held low, then a long clocked stream.
    tick(5);
    check("rst miso", 32'(MISO), 0);
    check("rst led", 32'(LED), 0);
    check("rst cmd_valid", 32'(CMD_VALID), 0);
    check("rst frame_done", 32'(FRAME_DONE), 0);
    check("rst frame_err", 32'(FRAME_ERR), 0);
`ifdef JSTK_FRAME_CNT_EN
    check("rst fcnt", 32'(FRAME_CNT), 0);
`endif
    RESET = 1'b0;
    MOSI = 1'b1;
    for (int i = 0; i < 120; i++) sck_pulse();
    check("arm done", done_cnt, 0);
    check("arm err", err_cnt, 0);
    check("arm cmd", cmd_cnt, 0);
    SS = 1'b1;
    tick(12);
    check("arm ss rise done", done_cnt, 0);
    check("arm ss rise err", err_cnt, 0);

    // Directed joystick frame.
    X_POS = 10'h2A5;
    Y_POS = 10'h1FF;
    BTN = 3'b101;
    mo[0] = 8'h83;
    for (int k = 1; k < 8; k++) mo[k] = 8'h00;
    run_frame("dir", 40, -1, '0);
    check("dir led const", 32'(LED), 32'h3);
    check("dir byte0 const", 32'(mi[0]), 32'hA5);
    check("dir byte3 const", 32'(mi[3]), 32'h01);

    // Non-command byte keeps LED.
    mo[0] = 8'h42;
    run_frame("badcmd", 40, -1, '0);

    // Short and long frames.
    mo[0] = 8'h81;
    run_frame("short", 28, -1, '0);
    mo[0] = 8'h00;
    run_frame("long", 48, -1, '0);

    // X change during byte 1 does not affect snapshot.
    X_POS = 10'h000;
    run_frame("snap", 40, 10, 10'h3FF);

    // SS low for one CLK: rise arrives while in LOAD.
    SS = 1'b0;
    tick(1);
    SS = 1'b1;
    tick(12);
    m_err++;
    check("glitch err", err_cnt, m_err);
    check("glitch done", done_cnt, m_done);

    // Reset mid-frame aborts without a pulse.
    SS = 1'b0;
    tick(12);
    for (int i = 0; i < 12; i++) sck_pulse();
    RESET = 1'b1;
    tick(3);
    RESET = 1'b0;
    SS = 1'b1;
    tick(12);
    m_led = 2'b00;
    check("abort led", 32'(LED), 32'(m_led));
    check("abort done", done_cnt, m_done);
    check("abort err", err_cnt, m_err);
`ifdef JSTK_FRAME_CNT_EN
    check("abort fcnt", 32'(FRAME_CNT), 0);
    m_done = 0;
    done_cnt = 0;
`endif

    // Random frames.
    for (int f = 0; f < 10; f++) begin
      int nb;
      X_POS = 10'($urandom_range(0, 1023));
      Y_POS = 10'($urandom_range(0, 1023));
      BTN = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++)
        mo[k] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1)
        mo[0] = 8'(128 + $urandom_range(0, 3));
      nb = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, 47)) : 40;
      run_frame($sformatf("rnd%0d", f), nb, -1, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
